// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period (rise-to-rise) and high time (rise-to-fall)
// of a slow asynchronous square wave, in clk_in cycles.
// Ports:
//   clk_in    - sole clock, rising edge
//   rst_n     - asynchronous active-low reset
//   sig_in    - asynchronous signal under measurement
//   period    - last measured rise-to-rise distance
//   high_time - last measured rise-to-fall distance
//   valid     - one-cycle pulse when period/high_time update
//   timeout   - sticky: no rise within TIMEOUT cycles; cleared on next valid
`timescale 1ns/100ps
module clk_period_meter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] TIMEOUT     = 32'd100_000_000
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        sig_in,
  output logic [31:0] period,
  output logic [31:0] high_time,
  output logic        valid,
  output logic        timeout
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_d_q, s_d_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       hi_cap_q, hi_cap_d;
  logic                   hi_seen_q, hi_seen_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic [CNT_W-1:0]       high_time_q, high_time_d;
  logic                   valid_q, valid_d;
  logic                   timeout_q, timeout_d;

  logic s_c, rise_c, fall_c;

  // Synchroniser shift and edge detection on the synchronised level
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
    s_c    = sync_q[SYNC_STAGES-1];
    s_d_d  = s_c;
    rise_c = s_c & ~s_d_q;
    fall_c = ~s_c & s_d_q;
  end

  // Next-state and measurement logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_cap_d    = hi_cap_q;
    hi_seen_d   = hi_seen_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = 1'b0;
    timeout_d   = timeout_q;

    case (state_q)
      IDLE: begin
        if (rise_c) begin
          cnt_d     = CNT_W'(1);
          hi_seen_d = 1'b0;
          state_d   = ARMED;
        end
      end
      ARMED: begin
        if (rise_c) begin
          // A rise on the TIMEOUT cycle still completes the measurement
          period_d    = cnt_q;
          high_time_d = hi_cap_q;
          valid_d     = 1'b1;
          timeout_d   = 1'b0;
          cnt_d       = CNT_W'(1);
          hi_seen_d   = 1'b0;
        end else begin
          if (fall_c && !hi_seen_q) begin
            hi_cap_d  = cnt_q;
            hi_seen_d = 1'b1;
          end
          if (cnt_q == TIMEOUT) begin
            // Hold cnt so it never wraps when TIMEOUT is the maximum value
            timeout_d = 1'b1;
            state_d   = IDLE;
          end else begin
            cnt_d = CNT_W'(cnt_q + CNT_W'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      s_d_q       <= 1'b0;
      cnt_q       <= '0;
      hi_cap_q    <= '0;
      hi_seen_q   <= 1'b0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      s_d_q       <= s_d_d;
      cnt_q       <= cnt_d;
      hi_cap_q    <= hi_cap_d;
      hi_seen_q   <= hi_seen_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_time_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Scoreboard bench for clk_period_meter: stimulus pushes expected results,
// a negedge monitor pops and compares on every valid pulse.
`timescale 1ns/100ps
module tb_clk_period_meter;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        sig_in;
  logic [31:0] period;
  logic [31:0] high_time;
  logic        valid;
  logic        timeout;

  clk_period_meter #(
    .SYNC_STAGES(2),
    .TIMEOUT    (32'd50)
  ) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .sig_in   (sig_in),
    .period   (period),
    .high_time(high_time),
    .valid    (valid),
    .timeout  (timeout)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] p_lo;
    logic [31:0] p_hi;
    logic [31:0] h_lo;
    logic [31:0] h_hi;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;
  int   n_valid  = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] lo, input logic [31:0] hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] p_lo, input logic [31:0] p_hi,
                          input logic [31:0] h_lo, input logic [31:0] h_hi,
                          input int n);
    exp_t x;
    x.p_lo = p_lo; x.p_hi = p_hi; x.h_lo = h_lo; x.h_hi = h_hi;
    for (int i = 0; i < n; i++) exp_q.push_back(x);
  endtask

  // Synchronous pattern: n cycles of hi high then lo low, driven on negedges
  task automatic gen(input int hi, input int lo, input int n);
    repeat (n) begin
      repeat (hi) begin @(negedge clk_in); sig_in = 1'b1; end
      repeat (lo) begin @(negedge clk_in); sig_in = 1'b0; end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_period"}, period, 32'd0, 32'd0);
    check({tag, "_high_time"}, high_time, 32'd0, 32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd0, 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0, 32'd0);
  endtask

  // Monitor: every valid must match the oldest expected result
  always @(negedge clk_in) begin
    if (rst_n === 1'b1 && valid === 1'b1) begin
      n_valid++;
      check("valid_single_cycle", 32'(prev_valid), 32'd0, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got period=%0d high_time=%0d, expected no valid at %0t",
                 period, high_time, $time);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("period[%0d]", n_valid), period, e.p_lo, e.p_hi);
        check($sformatf("high_time[%0d]", n_valid), high_time, e.h_lo, e.h_hi);
        check($sformatf("timeout_on_valid[%0d]", n_valid), 32'(timeout), 32'd0, 32'd0);
      end
    end
    prev_valid = (rst_n === 1'b1) ? valid : 1'b0;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    sig_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Divider 10: first rise only arms
    push_exp(32'd10, 32'd10, 32'd5, 32'd5, 5);
    gen(5, 5, 6);

    // 3 high / 7 low; first result still closes the previous 5/5 cycle
    push_exp(32'd10, 32'd10, 32'd5, 32'd5, 1);
    push_exp(32'd10, 32'd10, 32'd3, 32'd3, 3);
    gen(3, 7, 4);

    // Minimum input 1/1 after one transitional 3/7 result
    push_exp(32'd10, 32'd10, 32'd3, 32'd3, 1);
    push_exp(32'd2, 32'd2, 32'd1, 32'd1, 7);
    gen(1, 1, 8);

    // Timeout: last rise preceded edge E0; cnt hits 50 after E51, flag after E52
    repeat (51) @(posedge clk_in);
    @(negedge clk_in);
    check("timeout_before_limit", 32'(timeout), 32'd0, 32'd0);
    @(posedge clk_in);
    @(negedge clk_in);
    check("timeout_at_limit", 32'(timeout), 32'd1, 32'd1);
    repeat (5) @(negedge clk_in);
    check("timeout_sticky", 32'(timeout), 32'd1, 32'd1);
    check("period_kept", period, 32'd2, 32'd2);
    check("high_time_kept", high_time, 32'd1, 32'd1);

    // Re-arm from IDLE: arming rise leaves timeout set, next rise clears it
    gen(10, 10, 1);
    check("timeout_after_arm", 32'(timeout), 32'd1, 32'd1);
    push_exp(32'd20, 32'd20, 32'd10, 32'd10, 1);
    gen(10, 10, 1);
    check("timeout_cleared", 32'(timeout), 32'd0, 32'd0);

    // Rises exactly TIMEOUT apart: rise wins over timeout
    push_exp(32'd20, 32'd20, 32'd10, 32'd10, 1);
    push_exp(32'd50, 32'd50, 32'd25, 32'd25, 2);
    gen(25, 25, 3);
    check("timeout_at_exact_limit", 32'(timeout), 32'd0, 32'd0);

    // Mid-measurement asynchronous reset
    push_exp(32'd50, 32'd50, 32'd25, 32'd25, 1);
    push_exp(32'd10, 32'd10, 32'd5, 32'd5, 1);
    gen(5, 5, 2);
    check("period_before_reset", period, 32'd10, 32'd10);
    repeat (3) begin @(negedge clk_in); sig_in = 1'b1; end
    @(posedge clk_in);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    @(negedge clk_in);
    sig_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;
    push_exp(32'd10, 32'd10, 32'd5, 32'd5, 2);
    gen(5, 5, 3);

    // Let it time out back to IDLE before the asynchronous run
    repeat (60) @(negedge clk_in);
    check("timeout_before_async", 32'(timeout), 32'd1, 32'd1);

    // Asynchronous input, 406 ns period, 203 ns high: 40.6 / 20.3 cycles
    push_exp(32'd40, 32'd41, 32'd20, 32'd21, 19);
    #3.3;
    for (int i = 0; i < 20; i++) begin
      sig_in = 1'b1;
      #203;
      sig_in = 1'b0;
      #203;
    end
    repeat (10) @(negedge clk_in);
    check("timeout_after_async", 32'(timeout), 32'd0, 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
